rs232_packet_tx: RTL and testbench
==================================

Name: rs232_packet_tx

Overview:
- Serial transmitter for the 8-byte RS232 packet format used by the RX path.
- Triggered by the single-cycle tx_start pulse that the receiver raises after a valid read request.
- Latches the requested address and the 32-bit RAM read word, then serialises a frame on the TX line: 0x02, address byte, 4 data bytes, spare byte, 0x03.
- Format is 8N1, LSB first, at the same bit period the receiver uses.

Parameters:
- BIT_CYCLES, 2604: clocks per bit (50 MHz / 19200 baud); legal range 4..65535.
- GAP_BITS, 0: extra idle-high bit periods inserted after each byte's stop bit.
- SPARE_BYTE, 8'h00: value sent in byte 6.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  one-cycle request pulse; sampled only in IDLE.
- addr  in  7  RAM address of the request; captured on the accepted tx_start cycle.
- ram_out  in  32  RAM read data; captured one clock after the accepted tx_start.
- data_out  out  1  serial TX line; idles high.
- busy  out  1  high while a frame is loaded or in flight.
- tx_done  out  1  one-cycle pulse when the last stop bit (plus gap) completes.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): data_out=1, busy=0, tx_done=0, state=IDLE, all counters 0, frame register 0. Reset mid-frame aborts the frame; the line is high from the next edge.
- Frame byte order (byte0 sent first):
  - byte0 = 8'h02
  - byte1 = {1'b0, addr}
  - byte2 = ram[7:0], byte3 = ram[15:8], byte4 = ram[23:16], byte5 = ram[31:24]
  - byte6 = SPARE_BYTE
  - byte7 = 8'h03
  - A receiver of the same RX design reassembles this frame as data[47:16] = ram word and [14:8] = addr.
- Bit encoding: start bit 0, 8 data bits LSB first, stop bit 1. Every bit holds for exactly BIT_CYCLES clocks. data_out is registered (no combinational path to the pin).
- FSM states:
  - IDLE: data_out=1, busy=0. tx_start=1 -> capture addr, go to LOAD.
  - LOAD: capture ram_out, build 64-bit frame, clear byte_cnt, go to START; busy=1 from this cycle.
  - START: drive 0 for BIT_CYCLES, clear bit_cnt -> DATA.
  - DATA: drive current byte bit[bit_cnt] for BIT_CYCLES; bit_cnt increments each period; after bit 7 -> STOP.
  - STOP: drive 1 for (1+GAP_BITS)*BIT_CYCLES -> NEXT.
  - NEXT: one cycle. If byte_cnt==7, pulse tx_done and go to IDLE. Otherwise increment byte_cnt, shift the frame right 8, and go to START.
- Timing:
  - First start-bit edge on data_out appears 2 clocks after the accepted tx_start.
  - Per-byte time = (10+GAP_BITS)*BIT_CYCLES + 1 clocks (the +1 is the NEXT cycle).
  - tx_done pulses the clock after the final stop period ends. busy falls the same cycle as the tx_done pulse.
- Boundaries:
  - tx_start while busy is ignored (no queue, no error).
  - tx_start in the same cycle busy falls is ignored. The next tx_start in IDLE is accepted.
  - Back-to-back frames are legal once IDLE is reached.
  - addr and ram_out changes after capture do not affect the frame in flight.
  - Bit timer: counts 0..BIT_CYCLES-1 and wraps, producing a tick at BIT_CYCLES-1. Width is clog2(BIT_CYCLES). The timer restarts on every state entry.
  - bit_cnt is 3 bits, byte_cnt is 3 bits; neither wraps beyond 7.

Decomposition:
- Shared package rs232_pkg:
  - STX=8'h02, ETX=8'h03, PKT_BYTES=8.
  - DEFAULT_BIT_CYCLES=2604.
  - State encoding constants.
  - RX should migrate to these same constants.
- Sub-module rs232_bit_timer:
  - Parameter BIT_CYCLES.
  - Ports: clk, rst, restart, tick.
  - Reusable later to replace RX's 1.0/1.5-bit counters.

Test Plan:
- Use BIT_CYCLES=16 for speed unless stated.
- Reset then idle: hold 100 clocks -> data_out=1, busy=0, tx_done never pulses.
- Read response: addr=7'h15, ram_out=32'hDEADBEEF -> line decodes to bytes 02,15,EF,BE,AD,DE,00,03. Start-bit edge 2 clocks after tx_start. tx_done after 8*(10*16+1)=1288 clocks following LOAD.
- Loopback through the RX block at BIT_CYCLES=2604: RX data_out[47:16]=32'hDEADBEEF, [14:8]=7'h15, [63:56]=8'h03.
- Busy rejection: second tx_start with addr=7'h01 at 400 clocks into a frame -> the frame in flight is unchanged, exactly one tx_done pulse, no second frame.
- Reset mid-frame: rst at byte3 bit4 -> data_out=1 and busy=0 on the next edge, no tx_done. A new tx_start then sends a full correct frame.
- GAP_BITS=2, SPARE_BYTE=8'hA5: inter-byte high time is 3*16 clocks plus the 1-cycle NEXT state, and byte6 decodes as A5.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: constants, state encoding and frame builder shared by the RS232 TX and RX paths
package rs232_pkg;
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h03;
    localparam int PKT_BYTES = 8;
    localparam int DEFAULT_BIT_CYCLES = 2604;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT
    } tx_state_t;

    // byte0 sits in bits [7:0] so the frame can be shifted right one byte at a time
    function automatic logic [63:0] build_frame(input logic [6:0] addr, input logic [31:0] data, input logic [7:0] spare);
        return {ETX, spare, data, 1'b0, addr, STX};
    endfunction
endpackage

// File: rtl/rs232_bit_timer.sv
// rs232_bit_timer: free-running bit-period counter with a tick on the last clock of each period
module rs232_bit_timer
    import rs232_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [W-1:0] r_cnt;

    assign tick = r_cnt == W'(BIT_CYCLES - 1);

    // count 0..BIT_CYCLES-1 and wrap; restart realigns the period to a state entry
    always_ff @(posedge clk) begin
        if (rst || restart || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/rs232_packet_tx.sv
// rs232_packet_tx: serialises the 8-byte read-response frame as 8N1, LSB first
module rs232_packet_tx
    import rs232_pkg::*;
#(
    parameter int         BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int         GAP_BITS   = 0,
    parameter logic [7:0] SPARE_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [6:0]  addr,
    input  logic [31:0] ram_out,
    output logic        data_out,
    output logic        busy,
    output logic        tx_done
);
    localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    tx_state_t    r_state;
    tx_state_t    w_next;
    logic [6:0]   r_addr;
    logic [63:0]  r_frame;
    logic [2:0]   r_byte_cnt;
    logic [2:0]   r_bit_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic         r_data_out;
    logic         r_busy;
    logic         r_tx_done;
    logic         w_line;
    logic         w_done;
    logic         w_tick;
    logic         w_restart;
    logic         w_last_byte;

    assign w_last_byte = r_byte_cnt == 3'(PKT_BYTES - 1);
    assign w_restart   = w_next != r_state;
    assign data_out    = r_data_out;
    assign busy        = r_busy;
    assign tx_done     = r_tx_done;

    rs232_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // next state and the line level / done pulse to be registered
    always_comb begin
        w_next = r_state;
        w_line = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:  w_next = (tx_start && !r_tx_done) ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_START;
            S_START: begin
                w_line = 1'b0;
                w_next = w_tick ? S_DATA : S_START;
            end
            S_DATA: begin
                w_line = r_frame[r_bit_cnt];
                w_next = (w_tick && r_bit_cnt == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP:  w_next = (w_tick && r_gap_cnt == GW'(GAP_BITS)) ? S_NEXT : S_STOP;
            S_NEXT: begin
                w_done = w_last_byte;
                w_next = w_last_byte ? S_IDLE : S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // state and pin registers; busy follows the next state so it drops together with tx_done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data_out <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_data_out <= w_line;
            r_busy     <= w_next != S_IDLE;
            r_tx_done  <= w_done;
        end
    end

    // request capture, frame shifting and the bit/byte/gap counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_frame    <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE && w_next == S_LOAD)
                r_addr <= addr;
            if (r_state == S_LOAD) begin
                r_frame    <= build_frame(r_addr, ram_out, SPARE_BYTE);
                r_byte_cnt <= '0;
            end
            if (r_state == S_START)
                r_bit_cnt <= '0;
            else if (r_state == S_DATA && w_tick && r_bit_cnt != 3'd7)
                r_bit_cnt <= r_bit_cnt + 3'd1;
            r_gap_cnt <= (r_state != S_STOP) ? '0 : w_tick ? r_gap_cnt + GW'(1) : r_gap_cnt;
            if (r_state == S_NEXT && !w_last_byte) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_frame    <= r_frame >> 8;
            end
        end
    end
endmodule

// File: tb/tb_rs232_packet_tx.sv
// tb_rs232_packet_tx: cycle-accurate line/busy/done checks of two transmitter configurations
module tb_rs232_packet_tx;
    localparam int BC = 16;

    logic        clk;
    logic        rst;
    logic        tx_start;
    logic        sel;
    logic [6:0]  addr;
    logic [31:0] ram_out;
    logic        d0_line, d0_busy, d0_done;
    logic        d1_line, d1_busy, d1_done;
    logic        w_line, w_busy, w_done;
    int          n_vec;
    int          n_err;

    rs232_packet_tx #(.BIT_CYCLES(BC)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start & ~sel),
        .addr     (addr),
        .ram_out  (ram_out),
        .data_out (d0_line),
        .busy     (d0_busy),
        .tx_done  (d0_done)
    );

    rs232_packet_tx #(.BIT_CYCLES(BC), .GAP_BITS(2), .SPARE_BYTE(8'hA5)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start & sel),
        .addr     (addr),
        .ram_out  (ram_out),
        .data_out (d1_line),
        .busy     (d1_busy),
        .tx_done  (d1_done)
    );

    assign w_line = sel ? d1_line : d0_line;
    assign w_busy = sel ? d1_busy : d0_busy;
    assign w_done = sel ? d1_done : d0_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected line level n edges after the accepting edge, from the frame timeline
    function automatic logic exp_line(input int n, input logic [63:0] f, input int p, input int g);
        int m, k, r;
        if (n < 2) return 1'b1;
        m = n - 2;
        k = m / p;
        r = m % p;
        if (k >= 8) return 1'b1;
        if (r < BC) return 1'b0;
        if (r < 9 * BC) return f[8 * k + (r - BC) / BC];
        if (r < (10 + g) * BC + 1) return 1'b1;
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        check($sformatf("%s line", tag), 32'(w_line), 32'd1);
        check($sformatf("%s busy", tag), 32'(w_busy), 32'd0);
        check($sformatf("%s done", tag), 32'(w_done), 32'd0);
    endtask

    // one request on the selected DUT; intr injects a rejected request, rst_at aborts the frame
    task automatic send_frame(input logic s, input logic [6:0] a, input logic [31:0] d, input int intr, input int rst_at);
        int g, p, tail;
        logic [7:0] spare;
        logic [7:0] b[8];
        logic [63:0] f;
        g = s ? 2 : 0;
        spare = s ? 8'hA5 : 8'h00;
        p = (10 + g) * BC + 1;
        tail = 8 * p + 20;
        b = '{8'h02, {1'b0, a}, d[7:0], d[15:8], d[23:16], d[31:24], spare, 8'h03};
        for (int i = 0; i < 8; i++) f[8 * i +: 8] = b[i];
        sel = s;
        addr = a;
        ram_out = ~d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        ram_out = d;
        check("accept busy", 32'(w_busy), 32'd1);
        check("accept line", 32'(w_line), 32'd1);
        for (int n = 1; n <= tail; n++) begin
            tx_start = (n == intr || n == 8 * p + 2);
            addr = (n == intr) ? 7'h01 : 7'($urandom);
            if (n >= 2) ram_out = $urandom;
            rst = (n == rst_at);
            @(posedge clk);
            #1;
            tx_start = 1'b0;
            if (n == rst_at) begin
                rst = 1'b0;
                check_idle($sformatf("reset n=%0d", n));
                for (int i = 0; i < 30; i++) begin
                    @(posedge clk);
                    #1;
                    check_idle("post reset");
                end
                return;
            end
            check($sformatf("line n=%0d", n), 32'(w_line), 32'(exp_line(n, f, p, g)));
            check($sformatf("busy n=%0d", n), 32'(w_busy), 32'(n <= 8 * p));
            check($sformatf("done n=%0d", n), 32'(w_done), 32'(n == 8 * p + 1));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        tx_start = 1'b0;
        sel = 1'b0;
        addr = '0;
        ram_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst line0", 32'(d0_line), 32'd1);
        check("rst busy0", 32'(d0_busy), 32'd0);
        check("rst done0", 32'(d0_done), 32'd0);
        check("rst line1", 32'(d1_line), 32'd1);
        check("rst busy1", 32'(d1_busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check_idle("idle");
        end
        send_frame(1'b0, 7'h15, 32'hDEADBEEF, -1, -1);
        send_frame(1'b0, 7'h2A, 32'h0BADF00D, 400, -1);
        send_frame(1'b0, 7'h33, 32'h12345678, -1, 2 + 3 * 161 + BC + 4 * BC + 5);
        send_frame(1'b0, 7'h15, 32'hDEADBEEF, -1, -1);
        for (int i = 0; i < 3; i++)
            send_frame(1'b0, 7'($urandom), $urandom, ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 1200)) : -1, -1);
        send_frame(1'b1, 7'h15, 32'hDEADBEEF, -1, -1);
        send_frame(1'b1, 7'($urandom), $urandom, int'($urandom_range(3, 1500)), -1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
